neopix_frame_tx: RTL and testbench

Downstream consumer of the 512×32 pixel frame RAM. On a start pulse it reads `num_pixels_i` words from the RAM's read port and serializes each one onto a single WS2812-style one-wire output, MSB first. It then holds the line low for the latch interval and signals completion. It sits between the pixel RAM and the board pin driving the LED strip; the SPI front end writes the RAM and triggers frames through this block.

---
 rtl/neopix_pkg.sv | 26 ++
 rtl/neopix_bit_gen.sv | 61 ++++++
 rtl/neopix_frame_tx.sv | 181 ++++++++++++++++++
 tb/tb_neopix_frame_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared types and constants for the WS2812 frame transmitter.
// NEOPIX_RGBW_EN selects 32-bit RGBW pixels instead of 24-bit GRB.
package neopix_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_e;

`ifdef NEOPIX_RGBW_EN
  localparam int BITS_PER_PIX = 32;
`else
  localparam int BITS_PER_PIX = 24;
`endif
  localparam int BIT_CNT_W    = $clog2(BITS_PER_PIX);

  localparam int RAM_RD_LAT   = 2;
  localparam int MAX_PIX      = 512;

  localparam int T_BIT_DEF    = 62;
  localparam int T0H_DEF      = 20;
  localparam int T1H_DEF      = 40;
  localparam int T_LATCH_DEF  = 14000;

  function automatic logic [9:0] clamp_pix(input logic [9:0] n);
    return (n > 10'(MAX_PIX)) ? 10'(MAX_PIX) : n;
  endfunction

endpackage

// File: rtl/neopix_bit_gen.sv
// One-wire bit waveform generator: a load starts a T_BIT period whose high
// time depends on bit_val; bit_end marks the final cycle of the period.
module neopix_bit_gen #(
  parameter int T_BIT = 62,
  parameter int T0H   = 20,
  parameter int T1H   = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  input  logic bit_val,
  output logic dout,
  output logic bit_end
);

  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI0  = CW'(T0H);
  localparam logic [CW-1:0] HI1  = CW'(T1H);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          val_q, val_d;
  logic          act_q, act_d;
  logic          dout_q, dout_d;

  always_comb begin
    cnt_d   = cnt_q;
    val_d   = val_q;
    act_d   = act_q;
    bit_end = act_q && (cnt_q == LAST);
    if (load) begin
      // a load on the bit_end cycle chains the next bit with no gap
      cnt_d = '0;
      val_d = bit_val;
      act_d = 1'b1;
    end else if (bit_end) begin
      cnt_d = '0;
      act_d = 1'b0;
    end else if (act_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    dout_d = act_d && (cnt_d < (val_d ? HI1 : HI0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      val_q  <= 1'b0;
      act_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      act_q  <= act_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/neopix_frame_tx.sv
// Reads a frame of pixels from the 2-cycle-latency pixel RAM and streams it
// MSB first onto a WS2812 line, then holds the latch interval. NEOPIX_RGBW_EN
// (via neopix_pkg) selects 32 bits per pixel.
module neopix_frame_tx
  import neopix_pkg::*;
#(
  parameter int T_BIT   = T_BIT_DEF,
  parameter int T0H     = T0H_DEF,
  parameter int T1H     = T1H_DEF,
  parameter int T_LATCH = T_LATCH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [9:0]  num_pixels_i,
  output logic [8:0]  rdaddr_o,
  input  logic [31:0] q_i,
  output logic        dout_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int BP = BITS_PER_PIX;
  localparam int LW = $clog2(T_LATCH + 1);
  localparam logic [LW-1:0]        LAT_LAST = LW'(T_LATCH - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BP - 1);

  state_e                state_q, state_d;
  logic                  start_q, start_d;
  logic [9:0]            npix_q, npix_d;
  logic [9:0]            pix_cnt_q, pix_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BP-2:0]         shreg_q, shreg_d;
  logic [BP-1:0]         hold_q, hold_d;
  logic [8:0]            rdaddr_q, rdaddr_d;
  logic [RAM_RD_LAT:0]   vld_pipe_q, vld_pipe_d;
  logic [LW-1:0]         latch_cnt_q, latch_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic       issue;
  logic       bg_load, bg_val, bg_end;
  logic [9:0] nxt_pix;

  neopix_bit_gen #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) u_bit_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (bg_load),
    .bit_val (bg_val),
    .dout    (dout_o),
    .bit_end (bg_end)
  );

`ifdef NEOPIX_RGBW_EN
`else
  logic unused_hi;
  assign unused_hi = ^q_i[31:BP];
`endif

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    npix_d      = npix_q;
    pix_cnt_d   = pix_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    rdaddr_d    = rdaddr_q;
    latch_cnt_d = latch_cnt_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    bg_load     = 1'b0;
    bg_val      = 1'b0;
    nxt_pix     = pix_cnt_q + 10'd1;

    unique case (state_q)
      IDLE: begin
        // start is registered first so the count is captured with it
        if (start_q) begin
          rdaddr_d  = '0;
          pix_cnt_d = '0;
          bit_cnt_d = '0;
          if (npix_q == 10'd0) begin
            state_d     = LATCH;
            latch_cnt_d = '0;
          end else begin
            state_d = FETCH;
            issue   = 1'b1;
          end
        end else if (start_i) begin
          start_d = 1'b1;
          npix_d  = clamp_pix(num_pixels_i);
        end
      end
      FETCH: begin
        if (vld_pipe_q[RAM_RD_LAT]) begin
          shreg_d = q_i[BP-2:0];
          bg_load = 1'b1;
          bg_val  = q_i[BP-1];
          state_d = SHIFT;
          if (npix_q > 10'd1) begin
            rdaddr_d = 9'd1;
            issue    = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (vld_pipe_q[RAM_RD_LAT]) hold_d = q_i[BP-1:0];
        if (bg_end) begin
          if (bit_cnt_q != BIT_LAST) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = {shreg_q[BP-3:0], 1'b0};
            bg_load   = 1'b1;
            bg_val    = shreg_q[BP-2];
          end else if (nxt_pix == npix_q) begin
            state_d     = LATCH;
            latch_cnt_d = '0;
          end else begin
            pix_cnt_d = nxt_pix;
            bit_cnt_d = '0;
            shreg_d   = hold_q[BP-2:0];
            bg_load   = 1'b1;
            bg_val    = hold_q[BP-1];
            // prefetch the pixel after the one starting now, if any
            if ((nxt_pix + 10'd1) < npix_q) begin
              rdaddr_d = nxt_pix[8:0] + 9'd1;
              issue    = 1'b1;
            end
          end
        end
      end
      LATCH: begin
        if (latch_cnt_q == LAT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_pipe_d = {vld_pipe_q[RAM_RD_LAT-1:0], issue};
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      npix_q      <= '0;
      pix_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      rdaddr_q    <= '0;
      vld_pipe_q  <= '0;
      latch_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      npix_q      <= npix_d;
      pix_cnt_q   <= pix_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      rdaddr_q    <= rdaddr_d;
      vld_pipe_q  <= vld_pipe_d;
      latch_cnt_q <= latch_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rdaddr_o = rdaddr_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_neopix_frame_tx.sv
// Bench for neopix_frame_tx with shortened bit/latch timing so a full
// 512-pixel frame fits in the cycle budget; a waveform decoder feeds a bit scoreboard.
module tb_neopix_frame_tx;
  import neopix_pkg::*;

  localparam int TB_T_BIT   = 4;
  localparam int TB_T0H     = 1;
  localparam int TB_T1H     = 2;
  localparam int TB_T_LATCH = 30;
  localparam int BITS       = BITS_PER_PIX;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  num;
  logic [8:0]  rdaddr;
  logic [31:0] q;
  logic        dout, busy, done;

  logic [31:0] mem [512];
  logic [8:0]  ram_a;

  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;

  // monitor state
  bit dout_prev = 0, busy_prev = 0, in_bit = 0;
  int rise_c, fall_c, first_rise, busy_c, done_c;
  int n_done = 0, frame_bits = 0, frame_rises = 0;
  int hi, per, obs;
  bit fin, chk_per, e;
  bit exp_q[$];
  int addr_log[$];

  neopix_frame_tx #(.T_BIT(TB_T_BIT), .T0H(TB_T0H), .T1H(TB_T1H), .T_LATCH(TB_T_LATCH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_pixels_i(num),
    .rdaddr_o(rdaddr), .q_i(q), .dout_o(dout), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // RAM: registered address, registered output
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ram_a <= rdaddr;
    q     <= mem[ram_a];
  end

  // decode the line into bits and check them against the scoreboard
  always @(negedge clk) begin
    fin = 0; chk_per = 0;
    if (rst) begin
      in_bit = 0;
    end else begin
      if (busy && !busy_prev) begin
        busy_c = cyc; frame_bits = 0; frame_rises = 0;
        addr_log.delete(); addr_log.push_back(int'(rdaddr));
      end else if (busy && addr_log.size() > 0 && int'(rdaddr) != addr_log[$]) begin
        addr_log.push_back(int'(rdaddr));
      end
      if (dout && !dout_prev) begin
        if (in_bit) begin fin = 1; chk_per = 1; hi = fall_c - rise_c; per = cyc - rise_c; end
        if (frame_rises == 0) first_rise = cyc;
        frame_rises++; in_bit = 1; rise_c = cyc;
      end
      if (!dout && dout_prev) fall_c = cyc;
      if (done) begin
        done_c = cyc; n_done++;
        if (in_bit) begin fin = 1; hi = fall_c - rise_c; in_bit = 0; end
      end
    end
    if (fin) begin
      frame_bits++;
      obs = (hi == TB_T1H) ? 1 : (hi == TB_T0H) ? 0 : -1;
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL sb_extra_bit: got bit with high=%0d, want none", hi);
      end else begin
        e = exp_q.pop_front();
        if (obs != int'(e)) begin
          bad++; $display("FAIL sb_bit[%0d]: got %0d (high=%0d), want %0d", frame_bits-1, obs, hi, e);
        end
      end
      if (chk_per) begin
        total++;
        if (per != TB_T_BIT) begin
          bad++; $display("FAIL sb_period[%0d]: got %0d, want %0d", frame_bits-1, per, TB_T_BIT);
        end
      end
    end
    dout_prev = dout; busy_prev = busy;
  end

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++)
      for (int b = BITS - 1; b >= 0; b--) exp_q.push_back(mem[i][b]);
  endtask

  task automatic run_frame(input int n, input int budget, output bit timed_out);
    int d0;
    d0 = n_done;
    @(negedge clk); start = 1; num = n[9:0]; t0 = cyc + 1;
    @(negedge clk); start = 0;
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      if (n_done != d0) begin timed_out = 0; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; num = '0;
    repeat (3) @(negedge clk);
    total++; if (dout !== 1'b0)   begin bad++; $display("FAIL reset_dout: got %b want 0", dout); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rdaddr !== 9'd0) begin bad++; $display("FAIL reset_rdaddr: got %0d want 0", rdaddr); end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit to;
    mem[0] = 32'h00A50F3C;
    push_exp(1);
    run_frame(1, BITS*TB_T_BIT + TB_T_LATCH + 50, to);
    total++; if (to) begin bad++; $display("FAIL single_timeout: got no done, want done"); end
    total++; if (busy_c - t0 != 1) begin bad++; $display("FAIL single_busy_lat: got %0d want 1", busy_c - t0); end
    total++; if (first_rise - t0 != 4) begin bad++; $display("FAIL single_rise_lat: got %0d want 4", first_rise - t0); end
    total++; if (done_c - first_rise != BITS*TB_T_BIT + TB_T_LATCH) begin
      bad++; $display("FAIL single_frame_len: got %0d want %0d", done_c - first_rise, BITS*TB_T_BIT + TB_T_LATCH); end
    total++; if (frame_bits != BITS) begin bad++; $display("FAIL single_bits: got %0d want %0d", frame_bits, BITS); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_sb_left: got %0d want 0", exp_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit to;
    mem[0] = 32'h00FFFFFF; mem[1] = 32'h00000000; mem[2] = 32'h00800001;
    push_exp(3);
    run_frame(3, 3*BITS*TB_T_BIT + TB_T_LATCH + 50, to);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout: got no done, want done"); end
    total++; if (frame_bits != 3*BITS) begin bad++; $display("FAIL b2b_bits: got %0d want %0d", frame_bits, 3*BITS); end
    total++; if (done_c - first_rise != 3*BITS*TB_T_BIT + TB_T_LATCH) begin
      bad++; $display("FAIL b2b_frame_len: got %0d want %0d", done_c - first_rise, 3*BITS*TB_T_BIT + TB_T_LATCH); end
    total++; if (addr_log.size() != 3) begin bad++; $display("FAIL b2b_addr_cnt: got %0d want 3", addr_log.size()); end
    for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
      total++; if (addr_log[i] != i) begin bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, addr_log[i], i); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_sb_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_zero();
    bit to;
    run_frame(0, TB_T_LATCH + 50, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout: got no done, want done"); end
    total++; if (frame_rises != 0) begin bad++; $display("FAIL zero_dout: got %0d rises want 0", frame_rises); end
    total++; if (done_c - t0 != TB_T_LATCH + 1) begin bad++; $display("FAIL zero_done_lat: got %0d want %0d", done_c - t0, TB_T_LATCH + 1); end
  endtask

  task automatic test_start_busy();
    int d0;
    bit to;
    mem[0] = 32'h00C0FFEE; mem[1] = 32'h00123456;
    push_exp(2);
    d0 = n_done;
    @(negedge clk); start = 1; num = 10'd2;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    start = 1; num = 10'd5;
    @(negedge clk); start = 0;
    to = 1;
    for (int i = 0; i < 2*BITS*TB_T_BIT + TB_T_LATCH + 50; i++) begin
      if (n_done != d0) begin to = 0; break; end
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL busy_timeout: got no done, want done"); end
    total++; if (frame_bits != 2*BITS) begin bad++; $display("FAIL busy_bits: got %0d want %0d", frame_bits, 2*BITS); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_queued: got busy=%b want 0", busy); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL busy_done_cnt: got %0d want %0d", n_done - d0, 1); end
  endtask

  task automatic test_full_overflow();
    bit to;
    for (int i = 0; i < 512; i++) mem[i] = 32'(i) * 32'h00010203 + 32'h77000001;
    push_exp(512);
    run_frame(700, 512*BITS*TB_T_BIT + TB_T_LATCH + 50, to);
    total++; if (to) begin bad++; $display("FAIL full_timeout: got no done, want done"); end
    total++; if (frame_bits != 512*BITS) begin bad++; $display("FAIL full_bits: got %0d want %0d", frame_bits, 512*BITS); end
    total++; if (addr_log.size() != 512) begin bad++; $display("FAIL full_addr_cnt: got %0d want 512", addr_log.size()); end
    total++; if (addr_log.size() == 0 || addr_log[$] != 511) begin
      bad++; $display("FAIL full_last_addr: got %0d want 511", addr_log.size() ? addr_log[$] : -1); end
    total++; if (done_c - first_rise != 512*BITS*TB_T_BIT + TB_T_LATCH) begin
      bad++; $display("FAIL full_frame_len: got %0d want %0d", done_c - first_rise, 512*BITS*TB_T_BIT + TB_T_LATCH); end
    repeat (20) @(negedge clk);
    total++; if (rdaddr !== 9'd511) begin bad++; $display("FAIL full_addr_after: got %0d want 511", rdaddr); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_sb_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit to;
    for (int i = 0; i < 4; i++) mem[i] = 32'h00F0F0F0 ^ 32'(i);
    push_exp(4);
    @(negedge clk); start = 1; num = 10'd4;
    @(negedge clk); start = 0;
    to = 1;
    for (int i = 0; i < 4*BITS*TB_T_BIT; i++) begin
      if (frame_bits >= 2*BITS + 3) begin to = 0; break; end
      @(negedge clk);
    end
    total++; if (to) begin bad++; $display("FAIL rstmid_reach: got %0d bits want >= %0d", frame_bits, 2*BITS + 3); end
    d0 = n_done;
    rst = 1;
    @(negedge clk);
    total++; if (dout !== 1'b0)   begin bad++; $display("FAIL rstmid_dout: got %b want 0", dout); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    total++; if (rdaddr !== 9'd0) begin bad++; $display("FAIL rstmid_rdaddr: got %0d want 0", rdaddr); end
    rst = 0;
    exp_q.delete();
    repeat (4*BITS*TB_T_BIT + TB_T_LATCH + 20) @(negedge clk);
    total++; if (n_done != d0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n_done - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got busy=%b want 0", busy); end
  endtask

`ifdef NEOPIX_RGBW_EN
  task automatic test_rgbw();
    bit to;
    mem[0] = 32'h80000001;
    push_exp(1);
    run_frame(1, 32*TB_T_BIT + TB_T_LATCH + 50, to);
    total++; if (to) begin bad++; $display("FAIL rgbw_timeout: got no done, want done"); end
    total++; if (frame_bits != 32) begin bad++; $display("FAIL rgbw_bits: got %0d want 32", frame_bits); end
    total++; if (done_c - first_rise != 32*TB_T_BIT + TB_T_LATCH) begin
      bad++; $display("FAIL rgbw_frame_len: got %0d want %0d", done_c - first_rise, 32*TB_T_BIT + TB_T_LATCH); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_start_busy();
    test_reset_mid();
`ifdef NEOPIX_RGBW_EN
    test_rgbw();
`endif
    test_full_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
